apb_vgachargen_fifo: RTL and testbench

- Parametrised APB slave for the VGA character generator.
- Posts character writes into a FIFO (depth FIFO_DEPTH) and drains them to the character-memory write port with a valid/ready handshake.
- Adds readable control/status registers, a delivered-character counter, FIFO flush and back-pressure (APB wait states when the FIFO is full).
- Sits between the APB interconnect and the char-memory/timing core; the core is instantiated by the parent.

---
 rtl/apb_vgachargen_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_apb_vgachargen_fifo.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_vgachargen_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : apb_vgachargen_fifo
//  Description : APB slave for the VGA character generator. Character writes
//                are posted into a small FIFO and drained to the char-memory
//                write port over a valid/ready handshake. Also provides
//                CTRL / STATUS / WCOUNT registers, FIFO flush and APB wait
//                states while the FIFO is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_vgachargen_fifo #(
   parameter int APB_ADDR_WIDTH  = 13,
   parameter int APB_DATA_WIDTH  = 32,
   parameter int CHAR_ADDR_WIDTH = 12,
   parameter int CHAR_WIDTH      = 8,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic [APB_ADDR_WIDTH-1:0]  apb_paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]  apb_pwdata_i,
   input  logic                       apb_pwrite_i,
   input  logic                       apb_psel_i,
   input  logic                       apb_penable_i,
   output logic [APB_DATA_WIDTH-1:0]  apb_prdata_o,
   output logic                       apb_pready_o,
   output logic                       apb_pslverr_o,
   output logic                       cw_valid_o,
   input  logic                       cw_ready_i,
   output logic [CHAR_ADDR_WIDTH-1:0] cw_addr_o,
   output logic [CHAR_WIDTH-1:0]      cw_char_o,
   output logic                       video_en_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = CHAR_ADDR_WIDTH + CHAR_WIDTH;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_WCOUNT = 8'h08;

   // Registered state
   logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             video_en_q, video_en_d;
   logic [15:0]      wcount_q, wcount_d;

   // Decode and handshake terms
   logic                      access;
   logic                      char_sel;
   logic [7:0]                reg_off;
   logic                      reg_mapped;
   logic                      err;
   logic                      empty;
   logic                      full;
   logic                      done;
   logic                      push;
   logic                      pop;
   logic                      ctrl_wr;
   logic                      flush;
   logic                      wc_clr;
   logic [ENT_W-1:0]          head;
   logic [APB_DATA_WIDTH-1:0] rdata;
   logic                      unused_pwdata;

   // Only the low pwdata bits carry meaning; fold the rest into a sink.
   assign unused_pwdata = ^apb_pwdata_i;

   assign access   = apb_psel_i & apb_penable_i;
   assign char_sel = apb_paddr_i[APB_ADDR_WIDTH-1];
   assign reg_off  = apb_paddr_i[7:0];

   assign empty = (level_q == '0);
   // Full is taken from the registered level, so a pop in the stalled cycle
   // only releases the write on the following cycle.
   assign full  = (level_q == LVL_W'(FIFO_DEPTH));

   // Error classification for the current access.
   always_comb begin
      reg_mapped = (reg_off == OFF_CTRL) || (reg_off == OFF_STATUS) ||
                   (reg_off == OFF_WCOUNT);
      err = 1'b0;
      if (char_sel) begin
         err = ~apb_pwrite_i;
      end else begin
         err = ~reg_mapped | ((reg_off == OFF_STATUS) & apb_pwrite_i);
      end
   end

   assign apb_pready_o  = access & ~(char_sel & apb_pwrite_i & full);
   assign apb_pslverr_o = access & err;

   // A transfer takes effect only on the edge where it completes cleanly.
   assign done    = access & apb_pready_o & ~err;
   assign push    = done & char_sel & apb_pwrite_i;
   assign ctrl_wr = done & ~char_sel & apb_pwrite_i & (reg_off == OFF_CTRL);
   assign flush   = ctrl_wr & apb_pwdata_i[1];
   assign wc_clr  = done & ~char_sel & apb_pwrite_i & (reg_off == OFF_WCOUNT);
   assign pop     = ~empty & cw_ready_i;

   // Read data mux; zero outside a clean register read.
   always_comb begin
      rdata = '0;
      if (access && !err && !char_sel) begin
         case (reg_off)
            OFF_CTRL: begin
               rdata[0] = video_en_q;
            end
            OFF_STATUS: begin
               rdata[0]         = empty;
               rdata[1]         = full;
               rdata[8 +: LVL_W] = level_q;
            end
            OFF_WCOUNT: begin
               rdata[15:0] = wcount_q;
            end
            default: begin
               rdata = '0;
            end
         endcase
      end
   end

   assign apb_prdata_o = rdata;

   // Next-state for pointers, level, control bit and delivered counter.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      level_d    = level_q;
      video_en_d = video_en_q;
      wcount_d   = wcount_q;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      end

      if (ctrl_wr) begin
         video_en_d = apb_pwdata_i[0];
      end

      // A clear in the same cycle as a pop wins over the increment.
      if (wc_clr) begin
         wcount_d = '0;
      end else if (pop) begin
         wcount_d = wcount_q + 16'd1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         video_en_q <= 1'b0;
         wcount_q   <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         video_en_q <= video_en_d;
         wcount_q   <= wcount_d;
      end
   end

   // FIFO storage; a push never coincides with a flush (different targets).
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= {apb_paddr_i[CHAR_ADDR_WIDTH-1:0],
                             apb_pwdata_i[CHAR_WIDTH-1:0]};
      end
   end

   // Head entry is presented straight from storage, no write bypass.
   assign head       = mem_q[rd_ptr_q];
   assign cw_valid_o = ~empty;
   assign cw_addr_o  = head[ENT_W-1:CHAR_WIDTH];
   assign cw_char_o  = head[CHAR_WIDTH-1:0];
   assign video_en_o = video_en_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_vgachargen_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_vgachargen_fifo
//  Description : Self-checking bench for apb_vgachargen_fifo, with a queue
//                based reference model of the posting FIFO and registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_vgachargen_fifo;

   localparam int AW    = 13;
   localparam int DW    = 32;
   localparam int CAW   = 12;
   localparam int CW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [AW-1:0] paddr = '0;
   logic [DW-1:0] pwdata = '0;
   logic          pwrite = 1'b0;
   logic          psel = 1'b0;
   logic          penable = 1'b0;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;
   logic          cw_valid;
   logic          cw_ready = 1'b0;
   logic [CAW-1:0] cw_addr;
   logic [CW-1:0] cw_char;
   logic          video_en;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [CAW+CW-1:0] mq[$];
   logic              ven_m  = 1'b0;
   logic [15:0]       wc_m   = 16'd0;
   bit                mon_en = 1'b0;
   bit                stop   = 1'b0;

   always #5 clk = ~clk;

   apb_vgachargen_fifo #(
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .CHAR_ADDR_WIDTH(CAW),
      .CHAR_WIDTH     (CW),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .apb_paddr_i  (paddr),
      .apb_pwdata_i (pwdata),
      .apb_pwrite_i (pwrite),
      .apb_psel_i   (psel),
      .apb_penable_i(penable),
      .apb_prdata_o (prdata),
      .apb_pready_o (pready),
      .apb_pslverr_o(pslverr),
      .cw_valid_o   (cw_valid),
      .cw_ready_i   (cw_ready),
      .cw_addr_o    (cw_addr),
      .cw_char_o    (cw_char),
      .video_en_o   (video_en)
   );

   function automatic logic exp_err(input logic wr, input logic [AW-1:0] a);
      logic [7:0] off;
      off = a[7:0];
      if (a[AW-1]) return !wr;
      if (off == 8'h00 || off == 8'h08) return 1'b0;
      if (off == 8'h04) return wr;
      return 1'b1;
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      logic [DW-1:0] r;
      int            n;
      r = '0;
      n = mq.size();
      if (exp_err(1'b0, a)) return '0;
      if (a[7:0] == 8'h00) r = 32'(ven_m);
      if (a[7:0] == 8'h04) r = (32'(n) << 8) | (n == DEPTH ? 32'd2 : 32'd0) | (n == 0 ? 32'd1 : 32'd0);
      if (a[7:0] == 8'h08) r = 32'(wc_m);
      return r;
   endfunction

   // Char-port scoreboard: head must match the oldest posted write every
   // cycle it is valid, and a handshake retires it and counts a delivery.
   always begin
      @(negedge clk);
      #3;
      if (mon_en && rstn) begin
         total++;
         if (cw_valid !== (mq.size() != 0)) begin
            bad++;
            $display("FAIL cw_valid actual=%b required=%b", cw_valid, (mq.size() != 0));
         end else if (cw_valid) begin
            total++;
            if ({cw_addr, cw_char} !== mq[0]) begin
               bad++;
               $display("FAIL cw_head actual=%h required=%h", {cw_addr, cw_char}, mq[0]);
            end
            if (cw_ready) begin
               void'(mq.pop_front());
               wc_m = wc_m + 16'd1;
            end
         end
      end
   end

   // One APB transfer with bounded wait; updates the model when it completes.
   task automatic apb(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      output logic [DW-1:0] rd, output logic err, output int waits,
                      output logic [DW-1:0] exp_rd);
      logic e;
      bit   ok;
      e = exp_err(wr, a);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(negedge clk);
      penable = 1'b1; waits = 0; ok = 1'b1;
      #1;
      while (pready !== 1'b1) begin
         if (waits >= 200) begin
            total++; bad++;
            $display("FAIL apb_timeout addr=%h waits=%0d required pready=1", a, waits);
            ok = 1'b0;
            break;
         end
         @(negedge clk);
         #1;
         waits++;
      end
      rd     = prdata;
      err    = pslverr;
      exp_rd = model_read(a);
      @(posedge clk);
      if (ok && !e && wr) begin
         if (a[AW-1]) begin
            mq.push_back({a[CAW-1:0], wd[CW-1:0]});
         end else if (a[7:0] == 8'h00) begin
            ven_m = wd[0];
            if (wd[1]) mq.delete();
         end else if (a[7:0] == 8'h08) begin
            wc_m = 16'd0;
         end
      end
      #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic test_reset;
      logic [DW-1:0] rd, er;
      logic          err;
      int            w;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (prdata !== '0) begin bad++; $display("FAIL rst_prdata actual=%h required=0", prdata); end
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL rst_pready actual=%b required=0", pready); end
      total++; if (pslverr !== 1'b0) begin bad++; $display("FAIL rst_pslverr actual=%b required=0", pslverr); end
      total++; if (cw_valid !== 1'b0) begin bad++; $display("FAIL rst_cw_valid actual=%b required=0", cw_valid); end
      total++; if (video_en !== 1'b0) begin bad++; $display("FAIL rst_video_en actual=%b required=0", video_en); end
      @(negedge clk);
      rstn = 1'b1;
      mon_en = 1'b1;
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h1 || err !== 1'b0) begin bad++; $display("FAIL rst_status actual=%h/%b required=00000001/0", rd, err); end
      apb(1'b0, 13'h0000, '0, rd, err, w, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_ctrl actual=%h required=0", rd); end
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_wcount actual=%h required=0", rd); end
   endtask

   task automatic test_single_write;
      logic [DW-1:0] rd, er;
      logic          err;
      int            w;
      cw_ready = 1'b1;
      apb(1'b1, {1'b1, 12'h123}, 32'h41, rd, err, w, er);
      total++; if (w != 0 || err !== 1'b0) begin bad++; $display("FAIL single_wr waits=%0d err=%b required 0/0", w, err); end
      total++;
      if (cw_valid !== 1'b1 || cw_addr !== 12'h123 || cw_char !== 8'h41) begin
         bad++;
         $display("FAIL single_head actual=%b/%h/%h required=1/123/41", cw_valid, cw_addr, cw_char);
      end
      @(posedge clk);
      #1;
      total++; if (cw_valid !== 1'b0) begin bad++; $display("FAIL single_drop actual=%b required=0", cw_valid); end
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'd1) begin bad++; $display("FAIL single_wcount actual=%h required=1", rd); end
   endtask

   task automatic test_backpressure;
      logic [DW-1:0] rd, er;
      logic          err;
      int            w;
      cw_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apb(1'b1, {1'b1, 12'($urandom_range(0, 2399))}, 32'($urandom), rd, err, w, er);
         total++; if (w != 0 || err !== 1'b0) begin bad++; $display("FAIL bp_fill%0d waits=%0d err=%b required 0/0", i, w, err); end
      end
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h0402) begin bad++; $display("FAIL bp_status_full actual=%h required=00000402", rd); end
      fork
         apb(1'b1, {1'b1, 12'($urandom_range(0, 2399))}, 32'($urandom), rd, err, w, er);
         begin
            repeat (4) @(negedge clk);
            cw_ready = 1'b1;
            @(negedge clk);
            cw_ready = 1'b0;
         end
      join
      total++; if (w != 3 || err !== 1'b0) begin bad++; $display("FAIL bp_stall waits=%0d err=%b required 3/0", w, err); end
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h0402) begin bad++; $display("FAIL bp_status_refill actual=%h required=00000402", rd); end
      cw_ready = 1'b1;
      repeat (6) @(negedge clk);
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL bp_drained actual=%h required=00000001", rd); end
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'd6) begin bad++; $display("FAIL bp_wcount actual=%h required=6", rd); end
   endtask

   task automatic test_flush;
      logic [DW-1:0] rd, er;
      logic          err;
      int            w;
      cw_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apb(1'b1, {1'b1, 12'($urandom_range(0, 2399))}, 32'($urandom), rd, err, w, er);
      end
      apb(1'b1, 13'h0000, 32'h3, rd, err, w, er);
      total++;
      if (err !== 1'b0 || video_en !== 1'b1 || cw_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_apply err=%b video_en=%b cw_valid=%b required 0/1/0", err, video_en, cw_valid);
      end
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL flush_status actual=%h required=00000001", rd); end
      apb(1'b0, 13'h0000, '0, rd, err, w, er);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL flush_ctrl_read actual=%h required=00000001", rd); end
      cw_ready = 1'b1;
      apb(1'b1, {1'b1, 12'h7FF}, 32'h5A, rd, err, w, er);
      repeat (3) @(negedge clk);
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'd7) begin bad++; $display("FAIL flush_after_deliver actual=%h required=7", rd); end
      // Flush coinciding with a pop handshake: the pop still counts.
      cw_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         apb(1'b1, {1'b1, 12'($urandom_range(0, 2399))}, 32'($urandom), rd, err, w, er);
      end
      fork
         apb(1'b1, 13'h0000, 32'h3, rd, err, w, er);
         begin
            repeat (2) @(negedge clk);
            cw_ready = 1'b1;
            @(negedge clk);
            cw_ready = 1'b0;
         end
      join
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'd8) begin bad++; $display("FAIL flush_pop_count actual=%h required=8", rd); end
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL flush_pop_status actual=%h required=00000001", rd); end
   endtask

   task automatic test_errors;
      logic [DW-1:0] rd, er;
      logic          err;
      int            w;
      cw_ready = 1'b0;
      apb(1'b1, {1'b1, 12'h042}, 32'h33, rd, err, w, er);
      apb(1'b0, {1'b1, 12'h042}, '0, rd, err, w, er);
      total++; if (err !== 1'b1 || rd !== '0 || w != 0) begin bad++; $display("FAIL err_char_read err=%b rd=%h waits=%0d required 1/0/0", err, rd, w); end
      apb(1'b0, 13'h000C, '0, rd, err, w, er);
      total++; if (err !== 1'b1 || rd !== '0) begin bad++; $display("FAIL err_unmapped_rd err=%b rd=%h required 1/0", err, rd); end
      apb(1'b1, 13'h0004, 32'hFFFF, rd, err, w, er);
      total++; if (err !== 1'b1 || rd !== '0) begin bad++; $display("FAIL err_status_wr err=%b rd=%h required 1/0", err, rd); end
      apb(1'b1, 13'h0010, 32'h0, rd, err, w, er);
      total++; if (err !== 1'b1 || video_en !== 1'b1) begin bad++; $display("FAIL err_unmapped_wr err=%b video_en=%b required 1/1", err, video_en); end
      apb(1'b0, 13'h0104, '0, rd, err, w, er);
      total++; if (err !== 1'b0 || rd !== 32'h0100) begin bad++; $display("FAIL err_alias_status err=%b rd=%h required 0/00000100", err, rd); end
      cw_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_wcount_wrap;
      logic [DW-1:0] rd, er;
      logic          err;
      int            w;
      cw_ready = 1'b0;
      @(negedge clk);
      force dut.wcount_q = 16'hFFFF;
      @(negedge clk);
      release dut.wcount_q;
      wc_m = 16'hFFFF;
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'h0000FFFF) begin bad++; $display("FAIL wc_preload actual=%h required=0000ffff", rd); end
      cw_ready = 1'b1;
      apb(1'b1, {1'b1, 12'h001}, 32'h20, rd, err, w, er);
      repeat (2) @(negedge clk);
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL wc_wrap actual=%h required=0", rd); end
      cw_ready = 1'b0;
      apb(1'b1, {1'b1, 12'h002}, 32'h21, rd, err, w, er);
      apb(1'b1, {1'b1, 12'h003}, 32'h22, rd, err, w, er);
      fork
         apb(1'b1, 13'h0008, 32'($urandom), rd, err, w, er);
         begin
            repeat (2) @(negedge clk);
            cw_ready = 1'b1;
            @(negedge clk);
            cw_ready = 1'b0;
         end
      join
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL wc_clear_wins actual=%h required=0", rd); end
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h0100) begin bad++; $display("FAIL wc_clear_level actual=%h required=00000100", rd); end
      cw_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random;
      logic [DW-1:0] rd, er;
      logic          err;
      int            w;
      int            op;
      stop = 1'b0;
      fork
         begin
            while (!stop) begin
               @(negedge clk);
               cw_ready = ($urandom_range(0, 3) == 0);
            end
         end
         begin
            for (int i = 0; i < 150; i++) begin
               op = $urandom_range(0, 9);
               if (op <= 5) begin
                  apb(1'b1, {1'b1, 12'($urandom_range(0, 2399))}, 32'($urandom), rd, err, w, er);
                  total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_char_wr%0d err=%b required 0", i, err); end
               end else if (op <= 8) begin
                  apb(1'b0, 13'(4 * (op - 6)), '0, rd, err, w, er);
                  total++; if (rd !== er || err !== 1'b0) begin bad++; $display("FAIL rnd_read%0d off=%0d actual=%h required=%h", i, 4 * (op - 6), rd, er); end
               end else begin
                  apb(1'b1, 13'h0000, 32'($urandom_range(0, 3)), rd, err, w, er);
                  total++; if (video_en !== ven_m) begin bad++; $display("FAIL rnd_ctrl%0d video_en=%b required=%b", i, video_en, ven_m); end
               end
            end
            stop = 1'b1;
         end
      join
      cw_ready = 1'b1;
      repeat (8) @(negedge clk);
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL rnd_drained actual=%h required=00000001", rd); end
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== er) begin bad++; $display("FAIL rnd_wcount actual=%h required=%h", rd, er); end
   endtask

   task automatic test_reset_mid;
      logic [DW-1:0] rd, er;
      logic          err;
      int            w;
      cw_ready = 1'b0;
      apb(1'b1, 13'h0000, 32'h1, rd, err, w, er);
      apb(1'b1, {1'b1, 12'h010}, 32'h61, rd, err, w, er);
      apb(1'b1, {1'b1, 12'h011}, 32'h62, rd, err, w, er);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      mq.delete();
      ven_m = 1'b0;
      wc_m  = 16'd0;
      #1;
      total++;
      if (cw_valid !== 1'b0 || video_en !== 1'b0) begin
         bad++;
         $display("FAIL midrst_async cw_valid=%b video_en=%b required 0/0", cw_valid, video_en);
      end
      @(negedge clk);
      rstn = 1'b1;
      apb(1'b0, 13'h0004, '0, rd, err, w, er);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL midrst_status actual=%h required=00000001", rd); end
      apb(1'b0, 13'h0000, '0, rd, err, w, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_ctrl actual=%h required=0", rd); end
      apb(1'b0, 13'h0008, '0, rd, err, w, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_wcount actual=%h required=0", rd); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_backpressure();
      test_flush();
      test_errors();
      test_wcount_wrap();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
